// File: rtl/vectoring_mode_seq_if.sv
// Handshake and sign-stream bundle for the vectoring-mode CORDIC cell.
// The slave modport is the CORDIC cell; the master modport is the upstream/downstream side.
interface vectoring_mode_seq_if #(
    parameter int DATA_LENGTH = 13,
    parameter int ITER_IDX    = 3,
    parameter int NUM_SIGN    = 2
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [DATA_LENGTH-1:0] in_X;
    logic signed [DATA_LENGTH-1:0] in_Y;
    logic                          sign_valid;
    logic [NUM_SIGN-1:0]           sign_d;
    logic [ITER_IDX-1:0]           iter_num;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [DATA_LENGTH-1:0] out_X;
    logic signed [DATA_LENGTH-1:0] out_Y;
    logic                          out_flip;

    modport slave (
        input  in_valid, in_X, in_Y, out_ready,
        output in_ready, sign_valid, sign_d, iter_num,
        output out_valid, out_X, out_Y, out_flip
    );

    modport master (
        output in_valid, in_X, in_Y, out_ready,
        input  in_ready, sign_valid, sign_d, iter_num,
        input  out_valid, out_X, out_Y, out_flip
    );
endinterface

// File: rtl/vectoring_mode_seq.sv
// Iterative vectoring-mode CORDIC: two micro-rotations per clock, streams direction bits downstream.
// Optional macro QUADRANT_PRE_EN: negate inputs with X<0 at acceptance and report it on out_flip.
module vectoring_mode_seq #(
    parameter int DATA_LENGTH = 13,
    parameter int ITER_IDX    = 3,
    parameter int NUM_SIGN    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vectoring_mode_seq_if.slave  bus
);
    // Pair counter spans NUM_PAIRS = 2^(ITER_IDX-1); the last pair is the all-ones count.
    localparam int K_W = ITER_IDX - 1;
    localparam logic [K_W-1:0] K_LAST = '1;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    typedef struct packed {
        logic                          s;
        logic signed [DATA_LENGTH-1:0] x;
        logic signed [DATA_LENGTH-1:0] y;
    } rot_t;

    // One micro-rotation; must stay bit-identical to the rotation-mode cells that replay it.
    function automatic rot_t micro_rot(input logic signed [DATA_LENGTH-1:0] x,
                                       input logic signed [DATA_LENGTH-1:0] y,
                                       input logic [ITER_IDX-1:0]          sh);
        rot_t r;
        r.s = ~y[DATA_LENGTH-1];
        if (r.s) begin
            r.x = x + (y >>> sh);
            r.y = y - (x >>> sh);
        end else begin
            r.x = x - (y >>> sh);
            r.y = y + (x >>> sh);
        end
        return r;
    endfunction

    state_t                        state_q, state_d;
    logic signed [DATA_LENGTH-1:0] x_q, x_d, y_q, y_d;
    logic signed [DATA_LENGTH-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
    logic [K_W-1:0]                k_q, k_d;
    logic                          sign_valid_q, sign_valid_d;
    logic [NUM_SIGN-1:0]           sgn_q, sgn_d;
    logic [ITER_IDX-1:0]           iter_q, iter_d;
    logic                          out_valid_q, out_valid_d;
    logic                          flip_q, flip_d;

    logic                          flip_in;
    logic signed [DATA_LENGTH-1:0] in_x_lat, in_y_lat;
    rot_t                          r0, r1;

`ifdef QUADRANT_PRE_EN
    // Left half-plane inputs are rotated by 180 deg so the CORDIC range covers them.
    always_comb begin
        flip_in  = bus.in_X[DATA_LENGTH-1];
        in_x_lat = flip_in ? -bus.in_X : bus.in_X;
        in_y_lat = flip_in ? -bus.in_Y : bus.in_Y;
    end
`else
    assign flip_in  = 1'b0;
    assign in_x_lat = bus.in_X;
    assign in_y_lat = bus.in_Y;
`endif

    // Pair datapath: shifts 2k and 2k+1 chained combinationally on the current registers.
    always_comb begin
        r0 = micro_rot(x_q, y_q, {k_q, 1'b0});
        r1 = micro_rot(r0.x, r0.y, {k_q, 1'b1});
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        k_d          = k_q;
        sign_valid_d = 1'b0;
        sgn_d        = sgn_q;
        iter_d       = iter_q;
        out_valid_d  = out_valid_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        flip_d       = flip_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = ITER;
                    x_d     = in_x_lat;
                    y_d     = in_y_lat;
                    k_d     = '0;
                    flip_d  = flip_in;
                end
            end
            ITER: begin
                x_d          = r1.x;
                y_d          = r1.y;
                sgn_d        = {r1.s, r0.s};
                iter_d       = {k_q, 1'b0};
                sign_valid_d = 1'b1;
                k_d          = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_x_d     = r1.x;
                    out_y_d     = r1.y;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            k_q          <= '0;
            sign_valid_q <= 1'b0;
            sgn_q        <= '0;
            iter_q       <= '0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            flip_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            k_q          <= k_d;
            sign_valid_q <= sign_valid_d;
            sgn_q        <= sgn_d;
            iter_q       <= iter_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            flip_q       <= flip_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.sign_valid = sign_valid_q;
    assign bus.sign_d     = sgn_q;
    assign bus.iter_num   = iter_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_X      = out_x_q;
    assign bus.out_Y      = out_y_q;
    assign bus.out_flip   = flip_q;

endmodule

// File: doc/vectoring_mode_seq.md
Name: vectoring_mode_seq

Overview:
- Iterative vectoring-mode CORDIC stage in the QR-CORDIC array; directly upstream of the rotation-mode cells.
- Accepts one (X, Y) column-leader pair and drives Y toward zero, two micro-rotations per clock (shifts i and i+1).
- Streams the per-pair direction bits sign_d and shift index iter_num to downstream rotation cells, which replay the same rotations on the rest of the row.
- Final magnitude (unscaled CORDIC gain) and residual Y are returned with a valid/ready handshake.

Parameters:
- DATA_LENGTH, 13, width of X/Y datapath, two's complement.
- ITER_IDX, 3, width of iter_num; total micro-rotations = 2^ITER_IDX; NUM_PAIRS = 2^(ITER_IDX-1).
- NUM_SIGN, 2, sign bits per cycle (fixed at 2; other values unsupported).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input pair valid.
- in_ready  output  1  block idle, can accept.
- in_X  input  DATA_LENGTH  signed X.
- in_Y  input  DATA_LENGTH  signed Y.
- sign_valid  output  1  sign_d/iter_num valid this cycle.
- sign_d  output  NUM_SIGN  direction bits; [0] for shift iter_num, [1] for shift iter_num+1.
- iter_num  output  ITER_IDX  base shift of current pair (0,2,4,...).
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed.
- out_X  output  DATA_LENGTH  final X (magnitude x gain ~1.6468).
- out_Y  output  DATA_LENGTH  final residual Y.
- out_flip  output  1  pre-rotation by 180 deg applied (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, X/Y regs=0, sign_valid=0, sign_d=0, iter_num=0, out_valid=0, out_X=0, out_Y=0, out_flip=0; in_ready=1 once reset released. Reset mid-operation aborts; no partial outputs.
- FSM: IDLE -> ITER on in_valid && in_ready; ITER -> DONE after NUM_PAIRS cycles; DONE -> IDLE on out_ready.
- in_ready = (state==IDLE), combinational from state. in_valid ignored in ITER/DONE.
- Acceptance edge E0: latch in_X/in_Y, clear pair counter k=0.
- Each ITER cycle, with i=2k, combinational on current regs:
  - s0 = ~Y[MSB]; X1 = s0 ? X+(Y>>>i) : X-(Y>>>i); Y1 = s0 ? Y-(X>>>i) : Y+(X>>>i).
  - s1 = ~Y1[MSB]; X2 = s1 ? X1+(Y1>>>(i+1)) : X1-(Y1>>>(i+1)); Y2 = s1 ? Y1-(X1>>>(i+1)) : Y1+(X1>>>(i+1)).
  - Identical arithmetic to the downstream rotation cells, so replay is bit-exact.
- At edge E(k+1): X<=X2, Y<=Y2, sign_d<={s1,s0}, iter_num<=i, sign_valid<=1, k<=k+1.
- sign_valid high for exactly NUM_PAIRS consecutive cycles (after E1..E_NUM_PAIRS), low otherwise. No backpressure on the sign stream; downstream must consume every cycle.
- At edge E_NUM_PAIRS: state<=DONE, out_valid<=1, out_X/out_Y<=X2/Y2. out_valid rises in the same cycle as the last sign_valid.
- DONE: outputs held stable while out_ready=0. On an edge with out_ready=1: out_valid<=0, state<=IDLE. out_X/out_Y keep their values until the next result.
- Minimum period per vector: NUM_PAIRS+2 cycles.
- Arithmetic: all intermediates DATA_LENGTH bits, arithmetic right shift (floor), two's-complement wrap, no saturation or overflow flag. Input range is the caller's responsibility: |in| * 1.65 must be < 2^(DATA_LENGTH-1).
- Y==0 counts as non-negative (sign bit 1).

Optional Feature:
- Macro QUADRANT_PRE_EN.
- Defined: at acceptance, if in_X<0, latch -in_X and -in_Y (wrap; most-negative stays most-negative) and set out_flip=1 for that vector, held until the next acceptance. Downstream negates its row accordingly.
- Undefined: inputs latched unchanged; out_flip constant 0. Port list is identical in both builds.

Test Plan:
- Reset: rst_n low mid-ITER -> all outputs 0 asynchronously, in_ready=1 after release; next vector processes correctly.
- in_X=100, in_Y=0, out_ready=1 -> sign_d 01,00,01,11 with iter_num 0,2,4,6 on 4 consecutive sign_valid cycles; out_X=166, out_Y=-1.
- in_X=0, in_Y=0 -> sign_d=11 every pair, out_X=0, out_Y=0.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid/out_X/out_Y stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
- Back-to-back: in_valid held high with two vectors -> second accepted exactly NUM_PAIRS+2 cycles after the first; sign streams do not overlap.
- QUADRANT_PRE_EN build, in_X=-100, in_Y=0 -> out_flip=1, same sign stream and out_X=166, out_Y=-1 as the 100/0 case; non-macro build -> out_flip=0.
